// File: rtl/td4_pkg.sv
// ----------------------------------------------------------------------------
// td4_pkg
// Shared definitions for the TD4 multi-cycle control unit:
//   - opcode constants (upper nibble of the instruction word)
//   - sequencer state enumeration
//   - ALU source select encodings
//   - load-enable bit indices and one-hot load patterns
// ----------------------------------------------------------------------------
package td4_pkg;

  // Opcodes
  localparam logic [3:0] OP_ADD_A_IM = 4'b0000;
  localparam logic [3:0] OP_MOV_A_B  = 4'b0001;
  localparam logic [3:0] OP_IN_A     = 4'b0010;
  localparam logic [3:0] OP_MOV_A_IM = 4'b0011;
  localparam logic [3:0] OP_MOV_B_A  = 4'b0100;
  localparam logic [3:0] OP_ADD_B_IM = 4'b0101;
  localparam logic [3:0] OP_IN_B     = 4'b0110;
  localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
  localparam logic [3:0] OP_OUT_B    = 4'b1001;
  localparam logic [3:0] OP_OUT_IM   = 4'b1011;
  localparam logic [3:0] OP_JNC      = 4'b1110;
  localparam logic [3:0] OP_JMP      = 4'b1111;

  // Sequencer states; ST_HALT is only reachable when illegal-opcode halting
  // is compiled in.
  typedef enum logic [1:0] {
    ST_FETCH  = 2'b00,
    ST_DECODE = 2'b01,
    ST_EXEC   = 2'b10,
    ST_HALT   = 2'b11
  } state_t;

  // ALU source select
  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_IN   = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  // Load-enable bit indices
  localparam int LD_A   = 0;
  localparam int LD_B   = 1;
  localparam int LD_OUT = 2;
  localparam int LD_PC  = 3;

  // One-hot load patterns
  localparam logic [3:0] LOAD_NONE = 4'b0000;
  localparam logic [3:0] LOAD_A    = 4'b0001;
  localparam logic [3:0] LOAD_B    = 4'b0010;
  localparam logic [3:0] LOAD_OUT  = 4'b0100;
  localparam logic [3:0] LOAD_PC   = 4'b1000;

endpackage

// File: rtl/td4_op_decode.sv
// ----------------------------------------------------------------------------
// td4_op_decode
// Combinational opcode decoder used by the sequencer while in DECODE.
// Ports:
//   opcode  in  4  instruction opcode (IR upper nibble)
//   carry   in  1  current carry flag (value held before the coming EXEC)
//   load    out 4  one-hot load enables {PC, OUT, B, A}
//   sel     out 2  ALU source select
//   illegal out 1  opcode is undefined
// ----------------------------------------------------------------------------
module td4_op_decode
  import td4_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       carry,
  output logic [3:0] load,
  output logic [1:0] sel,
  output logic       illegal
);

  always_comb begin
    load    = LOAD_NONE;
    sel     = SEL_ZERO;
    illegal = 1'b0;
    case (opcode)
      OP_ADD_A_IM: begin load = LOAD_A;   sel = SEL_A;    end
      OP_MOV_A_B:  begin load = LOAD_A;   sel = SEL_B;    end
      OP_IN_A:     begin load = LOAD_A;   sel = SEL_IN;   end
      OP_MOV_A_IM: begin load = LOAD_A;   sel = SEL_ZERO; end
      OP_MOV_B_A:  begin load = LOAD_B;   sel = SEL_A;    end
      OP_ADD_B_IM: begin load = LOAD_B;   sel = SEL_B;    end
      OP_IN_B:     begin load = LOAD_B;   sel = SEL_IN;   end
      OP_MOV_B_IM: begin load = LOAD_B;   sel = SEL_ZERO; end
      OP_OUT_B:    begin load = LOAD_OUT; sel = SEL_B;    end
      OP_OUT_IM:   begin load = LOAD_OUT; sel = SEL_ZERO; end
      // Jump only when the flag from the previous instruction is clear.
      OP_JNC:      begin load = carry ? LOAD_NONE : LOAD_PC; sel = SEL_ZERO; end
      OP_JMP:      begin load = LOAD_PC;  sel = SEL_ZERO; end
      default:     begin illegal = 1'b1; end
    endcase
  end

endmodule

// File: rtl/td4_sequencer.sv
// ----------------------------------------------------------------------------
// td4_sequencer
// Fetch/decode/execute control unit for the parametrised TD4 core. Owns the
// program counter, instruction register and carry flag; fetches from program
// memory over a req/ack handshake and drives one-cycle load pulses, the ALU
// source select and the immediate into the datapath.
//
// Compile-time option:
//   TD4_SEQ_ILLEGAL_HALT_EN  defined  -> undefined opcodes enter HALT
//                            undefined-> undefined opcodes execute as NOP,
//                                        halted tied low
//
// Parameters:
//   DATA_W  register/immediate width (instruction = {opcode[3:0], imm})
//   ADDR_W  program counter width, must not exceed DATA_W
//
// Ports:
//   clk        in  1           rising-edge clock
//   n_reset    in  1           asynchronous active-low reset
//   imem_req   out 1           fetch request
//   imem_addr  out ADDR_W      fetch address (= pc)
//   imem_ack   in  1           fetch data valid, honoured only in FETCH
//   imem_data  in  4+DATA_W    instruction word
//   alu_carry  in  1           datapath adder carry-out
//   load       out 4           one-hot load enables {PC, OUT, B, A}
//   sel        out 2           ALU source select
//   imm        out DATA_W      immediate operand
//   pc         out ADDR_W      program counter
//   carry      out 1           registered carry flag
//   halted     out 1           HALT indicator
// ----------------------------------------------------------------------------
module td4_sequencer
  import td4_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              n_reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W+3:0] imem_data,
  input  logic              alu_carry,
  output logic [3:0]        load,
  output logic [1:0]        sel,
  output logic [DATA_W-1:0] imm,
  output logic [ADDR_W-1:0] pc,
  output logic              carry,
  output logic              halted
);

  localparam int INSTR_W = DATA_W + 4;

  generate
    if (ADDR_W > DATA_W) begin : g_param_check
      $error("td4_sequencer: ADDR_W (%0d) must not exceed DATA_W (%0d)", ADDR_W, DATA_W);
    end
  endgenerate

  state_t             state;
  logic [INSTR_W-1:0] ir;
  logic [3:0]         dec_load;
  logic [1:0]         dec_sel;
  logic               dec_illegal;

  td4_op_decode u_op_decode (
    .opcode  (ir[INSTR_W-1 -: 4]),
    .carry   (carry),
    .load    (dec_load),
    .sel     (dec_sel),
    .illegal (dec_illegal)
  );

  // The request is gated by reset so it is low while n_reset is asserted and
  // rises in the very first cycle after release.
  assign imem_req  = n_reset && (state == ST_FETCH);
  assign imem_addr = pc;
  assign imm       = ir[DATA_W-1:0];

`ifndef TD4_SEQ_ILLEGAL_HALT_EN
  logic illegal_unused;
  assign illegal_unused = dec_illegal;
  assign halted         = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state  <= ST_FETCH;
      pc     <= '0;
      ir     <= '0;
      carry  <= 1'b0;
      load   <= LOAD_NONE;
      sel    <= SEL_A;
`ifdef TD4_SEQ_ILLEGAL_HALT_EN
      halted <= 1'b0;
`endif
    end else begin
      case (state)
        // ---- FETCH: wait for memory, capture instruction ----
        ST_FETCH: begin
          if (imem_ack) begin
            ir    <= imem_data;
            state <= ST_DECODE;
          end
        end

        // ---- DECODE: register controls for the single EXEC cycle ----
        ST_DECODE: begin
`ifdef TD4_SEQ_ILLEGAL_HALT_EN
          if (dec_illegal) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else begin
            load  <= dec_load;
            sel   <= dec_sel;
            state <= ST_EXEC;
          end
`else
          // Undefined opcodes decode to LOAD_NONE and run as NOP.
          load  <= dec_load;
          sel   <= dec_sel;
          state <= ST_EXEC;
`endif
        end

        // ---- EXEC: controls visible for one cycle, commit PC/carry ----
        ST_EXEC: begin
          load <= LOAD_NONE;
          if (load[LD_PC]) begin
            // A taken jump leaves the flag untouched.
            pc <= ir[ADDR_W-1:0];
          end else begin
            pc    <= pc + ADDR_W'(1);
            carry <= alu_carry;
          end
          state <= ST_FETCH;
        end

        // ---- HALT: frozen until reset ----
        ST_HALT: begin
          state <= ST_HALT;
        end

        default: begin
          state <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_td4_sequencer.sv
module tb_td4_sequencer;

  localparam int DATA_W = 4;
  localparam int ADDR_W = 4;

`ifdef TD4_SEQ_ILLEGAL_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic              clk;
  logic              n_reset;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W+3:0] imem_data;
  logic              alu_carry;
  logic [3:0]        load;
  logic [1:0]        sel;
  logic [DATA_W-1:0] imm;
  logic [ADDR_W-1:0] pc;
  logic              carry;
  logic              halted;

  logic [7:0] prog [16];

  td4_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .alu_carry (alu_carry),
    .load      (load),
    .sel       (sel),
    .imm       (imm),
    .pc        (pc),
    .carry     (carry),
    .halted    (halted)
  );

  // Program memory: returns the word at the requested address.
  assign imem_data = prog[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural meaning of each opcode: {load[3:0], sel[1:0]}.
  function automatic logic [5:0] ref_ctrl(input logic [3:0] op, input bit c);
    case (op)
      4'h0: return {4'b0001, 2'b00};
      4'h1: return {4'b0001, 2'b01};
      4'h2: return {4'b0001, 2'b10};
      4'h3: return {4'b0001, 2'b11};
      4'h4: return {4'b0010, 2'b00};
      4'h5: return {4'b0010, 2'b01};
      4'h6: return {4'b0010, 2'b10};
      4'h7: return {4'b0010, 2'b11};
      4'h9: return {4'b0100, 2'b01};
      4'hB: return {4'b0100, 2'b11};
      4'hE: return {(c ? 4'b0000 : 4'b1000), 2'b11};
      4'hF: return {4'b1000, 2'b11};
      default: return {4'b0000, 2'b11};
    endcase
  endfunction

  function automatic bit is_illegal(input logic [3:0] op);
    return (op == 4'h8) || (op == 4'hA) || (op == 4'hC) || (op == 4'hD);
  endfunction

  // ---------------- behavioural model (instruction level) ----------------
  localparam int PH_FETCH = 0, PH_DECODE = 1, PH_EXEC = 2, PH_HALT = 3;
  int         m_pc;
  bit         m_carry;
  logic [7:0] m_ir;
  int         m_phase;
  int         halt_cnt;

  task automatic m_reset();
    m_pc = 0; m_carry = 1'b0; m_ir = 8'h00; m_phase = PH_FETCH; halt_cnt = 0;
  endtask

  // Advance the model across one rising edge given the inputs now driven.
  task automatic m_step();
    logic [3:0] op;
    bit taken;
    op = m_ir[7:4];
    case (m_phase)
      PH_FETCH: if (imem_ack) begin m_ir = prog[m_pc]; m_phase = PH_DECODE; end
      PH_DECODE: m_phase = (HALT_EN && is_illegal(op)) ? PH_HALT : PH_EXEC;
      PH_EXEC: begin
        taken = (op == 4'hF) || (op == 4'hE && !m_carry);
        if (taken) m_pc = int'(m_ir[3:0]);
        else begin
          m_pc    = (m_pc + 1) % 16;
          m_carry = alu_carry;
        end
        m_phase = PH_FETCH;
      end
      default: m_phase = PH_HALT;
    endcase
  endtask

  task automatic m_check();
    logic [5:0] ctl;
    ctl = ref_ctrl(m_ir[7:4], m_carry);
    chk("req",    32'(imem_req), 32'(m_phase == PH_FETCH));
    chk("pc",     32'(pc),       32'(m_pc));
    chk("carry",  32'(carry),    32'(m_carry));
    chk("halted", 32'(halted),   32'(m_phase == PH_HALT));
    chk("load",   32'(load),     (m_phase == PH_EXEC) ? 32'(ctl[5:2]) : 32'd0);
    if (m_phase == PH_FETCH) chk("addr", 32'(imem_addr), 32'(m_pc));
    if (m_phase == PH_DECODE || m_phase == PH_EXEC) chk("imm", 32'(imm), 32'(m_ir[3:0]));
    if (m_phase == PH_EXEC && !is_illegal(m_ir[7:4])) chk("sel", 32'(sel), 32'(ctl[1:0]));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},    32'(imem_req), 32'd0);
    chk({tag, "_pc"},     32'(pc),       32'd0);
    chk({tag, "_load"},   32'(load),     32'd0);
    chk({tag, "_sel"},    32'(sel),      32'd0);
    chk({tag, "_imm"},    32'(imm),      32'd0);
    chk({tag, "_carry"},  32'(carry),    32'd0);
    chk({tag, "_halted"}, 32'(halted),   32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_reset = 1'b0; imem_ack = 1'b0; alu_carry = 1'b0;
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    prog[0] = 8'h35;  // MOV A,5
    prog[1] = 8'hB9;  // OUT 9
    prog[2] = 8'hE7;  // JNC 7
    prog[7] = 8'h03;  // ADD A,3
    prog[8] = 8'hEC;  // JNC 12
    prog[9] = 8'h80;  // undefined

    // ---------------- directed, hand-computed expectations ----------------
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    n_reset = 1'b1; imem_ack = 1'b1;
    #1;
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", 32'(imem_addr), 32'd0);
    tick(); chk("dec0_load", 32'(load), 32'd0); chk("dec0_req", 32'(imem_req), 32'd0); chk("dec0_imm", 32'(imm), 32'd5);
    tick(); chk("mov_load", 32'(load), 32'b0001); chk("mov_sel", 32'(sel), 32'b11); chk("mov_imm", 32'(imm), 32'd5);
    tick(); chk("f1_pc", 32'(pc), 32'd1); chk("f1_req", 32'(imem_req), 32'd1); chk("f1_load", 32'(load), 32'd0);
    tick(); tick(); chk("out_load", 32'(load), 32'b0100); chk("out_imm", 32'(imm), 32'd9);
    tick(); chk("f2_pc", 32'(pc), 32'd2);
    tick(); tick(); chk("jnc0_load", 32'(load), 32'b1000);
    imem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", 32'(imem_addr), 32'd7);
    end
    imem_ack = 1'b1;
    tick(); chk("dec_add_imm", 32'(imm), 32'd3);
    tick(); chk("add_load", 32'(load), 32'b0001); chk("add_sel", 32'(sel), 32'b00);
    alu_carry = 1'b1;
    tick(); chk("f8_pc", 32'(pc), 32'd8); chk("f8_carry", 32'(carry), 32'd1);
    alu_carry = 1'b0;
    tick(); tick(); chk("jnc1_load", 32'(load), 32'b0000);
    tick(); chk("f9_pc", 32'(pc), 32'd9); chk("f9_carry", 32'(carry), 32'd0);
    tick(); tick();
    if (HALT_EN) begin
      chk("halt_flag", 32'(halted), 32'd1); chk("halt_req", 32'(imem_req), 32'd0);
      tick(); tick();
      chk("halt_pc", 32'(pc), 32'd9); chk("halt_load", 32'(load), 32'd0);
    end else begin
      chk("nop_load", 32'(load), 32'd0); chk("nop_halted", 32'(halted), 32'd0);
      tick(); chk("nop_pc", 32'(pc), 32'd10); chk("nop_req", 32'(imem_req), 32'd1);
    end

    // JMP 12 interrupted by reset in EXEC
    n_reset = 1'b0; prog[0] = 8'hFC;
    #1; chk_reset_vals("rst2");
    tick(); n_reset = 1'b1;
    tick(); tick(); chk("jmp_load", 32'(load), 32'b1000); chk("jmp_imm", 32'(imm), 32'd12);
    #2; n_reset = 1'b0;
    #1; chk("jmprst_pc", 32'(pc), 32'd0); chk("jmprst_load", 32'(load), 32'd0); chk("jmprst_req", 32'(imem_req), 32'd0);
    tick(); n_reset = 1'b1;
    #1; chk("restart_req", 32'(imem_req), 32'd1); chk("restart_addr", 32'(imem_addr), 32'd0);
    tick(); tick(); chk("jmp2_load", 32'(load), 32'b1000);
    tick(); chk("jmp2_pc", 32'(pc), 32'd12); chk("jmp2_carry", 32'(carry), 32'd0);

    // ---------------- randomized run against the model ----------------
    for (int i = 0; i < 16; i++) begin
      logic [7:0] w;
      w = 8'($urandom);
      if (is_illegal(w[7:4]) && $urandom_range(0, 2) != 0) w[7:4] = 4'h3;
      prog[i] = w;
    end
    @(negedge clk); n_reset = 1'b0;
    @(negedge clk); n_reset = 1'b1;
    m_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      imem_ack  = ($urandom_range(0, 99) < 55);
      alu_carry = 1'($urandom_range(0, 1));
      m_step();
      @(negedge clk);
      m_check();
      if (m_phase == PH_HALT) halt_cnt++;
      if (halt_cnt > 2 || $urandom_range(0, 99) == 0) begin
        n_reset = 1'b0;
        #1; chk_reset_vals("rrst");
        @(negedge clk);
        chk("rrst_hold_req", 32'(imem_req), 32'd0);
        n_reset = 1'b1;
        #1;
        chk("rrst_req", 32'(imem_req), 32'd1);
        chk("rrst_addr", 32'(imem_addr), 32'd0);
        m_reset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
